// File: rtl/pattern_detect_ctrl_if.sv
// ==== pattern_detect_if : host/stream <-> pattern_detect_ctrl bundle (rev 1.0) ====
`default_nettype none

interface pattern_detect_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic [TMO_W-1:0] cfg_timeout;
  logic             start;
  logic             abort;
  logic             bit_valid;
  logic             bit_in;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             timed_out;

  modport master (
    output cfg_pattern, cfg_len, cfg_target, cfg_timeout, start, abort, bit_valid, bit_in,
    input  busy, hit, match_count, done, timed_out
  );

  modport slave (
    input  cfg_pattern, cfg_len, cfg_target, cfg_timeout, start, abort, bit_valid, bit_in,
    output busy, hit, match_count, done, timed_out
  );
endinterface

`default_nettype wire

// File: rtl/pattern_detect_ctrl.sv
// ==== pattern_detect_ctrl : programmable serial pattern-match run controller (rev 1.0) ====
`default_nettype none

module pattern_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  pattern_detect_if.slave   bus
);

  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam logic [LEN_W-1:0] C_PAT_LEN = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_TMO  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_target;
  logic [TMO_W-1:0] r_timeout;
  logic [PAT_W-1:0] r_history;
  logic [LEN_W-1:0] r_fill;
  logic [TMO_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic             r_hit;
  logic             r_done;
  logic             r_timed_out;

  logic [PAT_W-1:0] w_history_next;
  logic [LEN_W-1:0] w_fill_next;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_bit_take;
  logic             w_match;
  logic             w_complete;
  logic             w_timeout_hit;
  logic             w_accept;
  logic             w_hit_set;
  logic             w_done_set;
  logic             w_tmo_set;

  assign w_bit_take     = (r_state == S_RUN) && bus.bit_valid;
  assign w_history_next = {r_history[PAT_W-2:0], bus.bit_in};
  assign w_fill_next    = (r_fill == C_PAT_LEN) ? r_fill : r_fill + 1'b1;
  assign w_len_clamped  = (bus.cfg_len > C_PAT_LEN) ? C_PAT_LEN : bus.cfg_len;
  assign w_count_inc    = (&r_count) ? r_count : r_count + 1'b1;

  // Only the low r_len bits of history and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_match       = w_bit_take && (w_fill_next >= r_len) &&
                         ((w_history_next & w_mask) == (r_pattern & w_mask));
  assign w_complete    = w_match && (r_target != '0) && (w_count_inc == r_target);
  assign w_timeout_hit = (r_timeout != '0) && (r_timer == r_timeout - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority in RUN: abort, then completion, then timeout.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_hit_set    = 1'b0;
    w_done_set   = 1'b0;
    w_tmo_set    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_hit_set = w_match;
          if (w_complete) begin
            w_state_next = S_DONE;
            w_done_set   = 1'b1;
          end else if (w_timeout_hit) begin
            w_state_next = S_TMO;
            w_tmo_set    = 1'b1;
          end
        end
      end
      default: begin
        if (bus.start && (bus.cfg_len != '0)) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern   <= '0;
      r_len       <= '0;
      r_target    <= '0;
      r_timeout   <= '0;
      r_history   <= '0;
      r_fill      <= '0;
      r_timer     <= '0;
      r_count     <= '0;
      r_hit       <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_hit  <= w_hit_set;
      r_done <= w_done_set;
      if (w_accept) begin
        r_pattern   <= bus.cfg_pattern;
        r_len       <= w_len_clamped;
        r_target    <= bus.cfg_target;
        r_timeout   <= bus.cfg_timeout;
        r_history   <= '0;
        r_fill      <= '0;
        r_timer     <= '0;
        r_count     <= '0;
        r_timed_out <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_timer <= r_timer + 1'b1;
        if (w_bit_take) begin
          r_history <= w_history_next;
          r_fill    <= w_fill_next;
        end
        if (w_hit_set) begin
          r_count <= w_count_inc;
        end
        if (w_tmo_set) begin
          r_timed_out <= 1'b1;
        end
      end
    end
  end

  assign bus.busy        = (r_state == S_RUN);
  assign bus.hit         = r_hit;
  assign bus.done        = r_done;
  assign bus.match_count = r_count;
  assign bus.timed_out   = r_timed_out;

endmodule

`default_nettype wire

// File: tb/tb_pattern_detect_ctrl.sv
// ==== tb_pattern_detect_ctrl : directed self-checking bench for pattern_detect_ctrl (rev 1.0) ====
`default_nettype none

module tb_pattern_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pattern_detect_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

  pattern_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] tgt, input logic [15:0] tmo);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_target  = tgt;
    bus.cfg_timeout = tmo;
    bus.start       = 1'b1;
    cyc();
    bus.start       = 1'b0;
  endtask

  task automatic feed(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    cyc();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  initial begin
    logic       s1   [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic       e1   [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic       s2   [4] = '{1, 0, 1, 1};
    logic [7:0] pat5 = 8'hA5;
    int         hits;
    int         busy_cnt;
    int         done_cnt;

    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_target  = '0;
    bus.cfg_timeout = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;

    repeat (3) cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timed_out", bus.timed_out, 0);
    chk("rst_count", bus.match_count, 0);
    rst_n = 1'b1;
    cyc();

    // Overlapping matches of 1011 reach target 2 on the seventh bit.
    start_run(8'b1011, 4'd4, 8'd2, 16'd0);
    chk("t1_busy_start", bus.busy, 1);
    chk("t1_count_start", bus.match_count, 0);
    for (int i = 0; i < 7; i++) begin
      feed(s1[i]);
      chk($sformatf("t1_hit_bit%0d", i), bus.hit, e1[i]);
    end
    chk("t1_done", bus.done, 1);
    chk("t1_busy_end", bus.busy, 0);
    chk("t1_count", bus.match_count, 2);
    cyc();
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_count_hold", bus.match_count, 2);

    // Gaps with bit_valid low must not shift history.
    start_run(8'b1011, 4'd4, 8'd0, 16'd0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      feed(s2[i]);
      hits += int'(bus.hit);
      cyc();
      hits += int'(bus.hit);
    end
    chk("t2_hits", hits, 1);
    repeat (5) cyc();
    chk("t2_busy_unlimited", bus.busy, 1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    chk("t2_busy_abort", bus.busy, 0);
    chk("t2_count_abort", bus.match_count, 1);
    cyc();
    chk("t2_idle_stays", bus.busy, 0);

    // Timeout of 10 cycles on an all-zero stream.
    start_run(8'b1011, 4'd4, 8'd3, 16'd10);
    busy_cnt = 0;
    done_cnt = 0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b0;
    repeat (15) begin
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      cyc();
    end
    bus.bit_valid = 1'b0;
    chk("t3_busy_cycles", busy_cnt, 10);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_timed_out", bus.timed_out, 1);
    chk("t3_busy_end", bus.busy, 0);
    start_run(8'b1011, 4'd4, 8'd0, 16'd0);
    chk("t3_restart_clear", bus.timed_out, 0);
    chk("t3_restart_busy", bus.busy, 1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;

    // Completion on the same cycle the timer reaches timeout-1.
    start_run(8'b0000_0011, 4'd2, 8'd1, 16'd5);
    repeat (3) cyc();
    feed(1'b1);
    chk("t4_no_early_hit", bus.hit, 0);
    feed(1'b1);
    chk("t4_done", bus.done, 1);
    chk("t4_hit", bus.hit, 1);
    chk("t4_busy", bus.busy, 0);
    chk("t4_timed_out", bus.timed_out, 0);
    chk("t4_count", bus.match_count, 1);
    cyc();
    chk("t4_timed_out_later", bus.timed_out, 0);

    // Zero length is ignored; oversize length clamps to PAT_W.
    start_run(8'hA5, 4'd0, 8'd0, 16'd0);
    chk("t5_len0_busy", bus.busy, 0);
    chk("t5_len0_count", bus.match_count, 1);
    start_run(pat5, 4'd12, 8'd0, 16'd0);
    chk("t5_clamp_busy", bus.busy, 1);
    for (int i = 7; i >= 0; i--) begin
      feed(pat5[i]);
      chk($sformatf("t5_hit_bit%0d", 7 - i), bus.hit, (i == 0) ? 1 : 0);
    end
    chk("t5_count1", bus.match_count, 1);
    bus.cfg_pattern = 8'hFF;
    bus.cfg_len     = 4'd8;
    bus.start       = 1'b1;
    cyc();
    bus.start       = 1'b0;
    chk("t5_run_start_busy", bus.busy, 1);
    chk("t5_run_start_count", bus.match_count, 1);
    hits = 0;
    for (int i = 7; i >= 0; i--) begin
      feed(pat5[i]);
      hits += int'(bus.hit);
    end
    chk("t5_latched_hits", hits, 1);
    chk("t5_count2", bus.match_count, 2);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t5_abort_wins", bus.busy, 0);
    chk("t5_abort_count", bus.match_count, 2);

    // Asynchronous reset in the middle of a run.
    start_run(8'b1011, 4'd4, 8'd0, 16'd0);
    for (int i = 0; i < 4; i++) feed(s2[i]);
    chk("t6_hit_before", bus.hit, 1);
    chk("t6_count_before", bus.match_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_async", bus.busy, 0);
    chk("t6_hit_async", bus.hit, 0);
    chk("t6_done_async", bus.done, 0);
    chk("t6_count_async", bus.match_count, 0);
    cyc();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      feed(s2[i]);
      hits += int'(bus.hit);
    end
    cyc();
    hits += int'(bus.hit);
    chk("t6_ignored_hits", hits, 0);
    chk("t6_ignored_count", bus.match_count, 0);
    chk("t6_ignored_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
